// File: rtl/cdm_pipe_mult.sv
// Pipelined carry-disregard approximate multiplier with valid/ready on both sides.
// Optional error statistics are enabled by defining CDM_ERR_STAT_EN.
module cdm_pipe_mult #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned APPROX_COLS = 8,
  parameter int unsigned STAGES      = 2,
  parameter int unsigned ACC_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   R,
  output logic                 out_mode
`ifdef CDM_ERR_STAT_EN
  ,
  input  logic                 stat_clr,
  output logic [2*WIDTH-1:0]   err,
  output logic [ACC_W-1:0]     err_acc,
  output logic [2*WIDTH-1:0]   err_max,
  output logic [ACC_W-1:0]     n_txn
`endif
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int          W  = int'(WIDTH);
  localparam int          K  = int'(APPROX_COLS);

  if (STAGES < 1 || APPROX_COLS > 2 * WIDTH || ACC_W < 1) begin : g_param_check
    $error("cdm_pipe_mult: illegal parameter set");
  end

  // Low K columns are parity-only; everything at or above column K is summed exactly.
  function automatic logic [PW-1:0] cdm_mul(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [PW-1:0] lo;
    logic [PW-1:0] hi;
    lo = '0;
    hi = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        if (i + j < K) begin
          lo = lo ^ (PW'(a[i] & b[j]) << (i + j));
        end else begin
          hi = hi + (PW'(a[i] & b[j]) << (i + j - K));
        end
      end
    end
    return lo | (hi << K);
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Operands as seen by the final (compute) stage.
  logic             f_vld;
  logic [WIDTH-1:0] f_a;
  logic [WIDTH-1:0] f_b;
  logic             f_mode;

  if (STAGES > 1) begin : g_op_pipe
    localparam int unsigned N = STAGES - 1;
    logic [N-1:0]     vld_q;
    logic [N-1:0]     mode_q;
    logic [WIDTH-1:0] a_q [N];
    logic [WIDTH-1:0] b_q [N];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q  <= '0;
        mode_q <= '0;
        for (int i = 0; i < int'(N); i++) begin
          a_q[i] <= '0;
          b_q[i] <= '0;
        end
      end else if (adv) begin
        vld_q[0]  <= in_valid;
        mode_q[0] <= mode;
        a_q[0]    <= A;
        b_q[0]    <= B;
        for (int i = 1; i < int'(N); i++) begin
          vld_q[i]  <= vld_q[i-1];
          mode_q[i] <= mode_q[i-1];
          a_q[i]    <= a_q[i-1];
          b_q[i]    <= b_q[i-1];
        end
      end
    end

    assign f_vld  = vld_q[N-1];
    assign f_mode = mode_q[N-1];
    assign f_a    = a_q[N-1];
    assign f_b    = b_q[N-1];
  end else begin : g_no_op_pipe
    assign f_vld  = in_valid;
    assign f_mode = mode;
    assign f_a    = A;
    assign f_b    = B;
  end

  logic [PW-1:0] exact_d;
  logic [PW-1:0] res_d;

  always_comb begin
    exact_d = {{WIDTH{1'b0}}, f_a} * {{WIDTH{1'b0}}, f_b};
    res_d   = f_mode ? cdm_mul(f_a, f_b) : exact_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      R         <= '0;
      out_mode  <= 1'b0;
    end else if (adv) begin
      out_valid <= f_vld;
      if (f_vld) begin
        R        <= res_d;
        out_mode <= f_mode;
      end
    end
  end

`ifdef CDM_ERR_STAT_EN
  localparam int unsigned       SW       = ((ACC_W > PW) ? ACC_W : PW) + 1;
  localparam logic [ACC_W-1:0]  ACC_ONES = '1;

  logic              xfer;
  logic [SW-1:0]     acc_sum;
  logic [ACC_W-1:0]  err_acc_d;
  logic [PW-1:0]     err_max_d;
  logic [ACC_W-1:0]  n_txn_d;

  assign xfer = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= '0;
    end else if (adv && f_vld) begin
      err <= exact_d - res_d;
    end
  end

  always_comb begin
    acc_sum   = SW'(err_acc) + SW'(err);
    err_acc_d = err_acc;
    err_max_d = err_max;
    n_txn_d   = n_txn;
    if (stat_clr) begin
      err_acc_d = '0;
      err_max_d = '0;
      n_txn_d   = '0;
    end else if (xfer) begin
      err_acc_d = (acc_sum > SW'(ACC_ONES)) ? ACC_ONES : acc_sum[ACC_W-1:0];
      if (err > err_max) begin
        err_max_d = err;
      end
      if (n_txn != ACC_ONES) begin
        n_txn_d = n_txn + ACC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_acc <= '0;
      err_max <= '0;
      n_txn   <= '0;
    end else begin
      err_acc <= err_acc_d;
      err_max <= err_max_d;
      n_txn   <= n_txn_d;
    end
  end
`endif

endmodule

// File: tb/tb_cdm_pipe_mult.sv
// Bench for cdm_pipe_mult: default 8x8/K=8/2-stage instance plus a 4x4/K=3/1-stage instance,
// results checked through per-instance scoreboards against a column-count reference model.
module tb_cdm_pipe_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        in_valid, in_ready, mode, out_valid, out_ready, out_mode;
  logic [7:0]  A, B;
  logic [15:0] R;

  logic        in_valid2, in_ready2, mode2, out_valid2, out_ready2, out_mode2;
  logic [3:0]  A2, B2;
  logic [7:0]  R2;

`ifdef CDM_ERR_STAT_EN
  logic        stat_clr, stat_clr2;
  logic [15:0] err, err_max;
  logic [31:0] err_acc, n_txn;
  logic [7:0]  err2, err_max2;
  logic [31:0] err_acc2, n_txn2;
`endif

  cdm_pipe_mult #(.WIDTH(8), .APPROX_COLS(8), .STAGES(2), .ACC_W(32)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R),
    .out_mode  (out_mode)
`ifdef CDM_ERR_STAT_EN
    ,
    .stat_clr  (stat_clr),
    .err       (err),
    .err_acc   (err_acc),
    .err_max   (err_max),
    .n_txn     (n_txn)
`endif
  );

  cdm_pipe_mult #(.WIDTH(4), .APPROX_COLS(3), .STAGES(1), .ACC_W(32)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .A         (A2),
    .B         (B2),
    .mode      (mode2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .R         (R2),
    .out_mode  (out_mode2)
`ifdef CDM_ERR_STAT_EN
    ,
    .stat_clr  (stat_clr2),
    .err       (err2),
    .err_acc   (err_acc2),
    .err_max   (err_max2),
    .n_txn     (n_txn2)
`endif
  );

  typedef struct {
    logic [15:0] r;
    logic        m;
    logic [15:0] e;
  } exp_t;

  exp_t sb1[$];
  exp_t sb2[$];

  int      n_checks = 0;
  int      n_fail   = 0;
  int      n_out1   = 0;
  int      n_out2   = 0;
  longint  err_sum2 = 0;
  int      err_max2_exp = 0;

  // Reference: per-column popcount; low columns keep only parity, upper columns full weight.
  function automatic logic [31:0] ref_mul(input int w, input int k, input logic [15:0] a,
                                          input logic [15:0] b, input logic m);
    logic [31:0] lo, hi, ex;
    ex = 32'(a) * 32'(b);
    if (!m) return ex;
    lo = '0;
    hi = '0;
    for (int c = 0; c < 2 * w; c++) begin
      int cnt = 0;
      for (int i = 0; i < w; i++) begin
        int j = c - i;
        if (j >= 0 && j < w) cnt += int'((a >> i) & (b >> j) & 16'd1);
      end
      if (c < k) lo = lo | (32'(cnt & 1) << c);
      else       hi = hi + (32'(cnt) << c);
    end
    return lo | hi;
  endfunction

  always @(negedge clk) begin : mon1
    exp_t        e;
    logic [31:0] ap, ex;
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_checks++;
        n_out1++;
        if (sb1.size() == 0) begin
          n_fail++;
          $display("FAIL sb1_extra: got R=%h, expected no output", R);
        end else begin
          e = sb1.pop_front();
          if (R !== e.r || out_mode !== e.m) begin
            n_fail++;
            $display("FAIL sb1_result: got R=%h mode=%b, expected R=%h mode=%b",
                     R, out_mode, e.r, e.m);
          end
`ifdef CDM_ERR_STAT_EN
          n_checks++;
          if (err !== e.e) begin
            n_fail++;
            $display("FAIL sb1_err: got err=%0d, expected %0d", err, e.e);
          end
`endif
        end
      end
      if (in_valid && in_ready) begin
        ap  = ref_mul(8, 8, 16'(A), 16'(B), mode);
        ex  = ref_mul(8, 8, 16'(A), 16'(B), 1'b0);
        e.r = ap[15:0];
        e.m = mode;
        e.e = 16'(ex - ap);
        sb1.push_back(e);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t        e;
    logic [31:0] ap, ex;
    if (!rst) begin
      if (out_valid2 && out_ready2) begin
        n_checks++;
        n_out2++;
        if (sb2.size() == 0) begin
          n_fail++;
          $display("FAIL sb2_extra: got R=%h, expected no output", R2);
        end else begin
          e = sb2.pop_front();
          if ({8'h00, R2} !== e.r || out_mode2 !== e.m) begin
            n_fail++;
            $display("FAIL sb2_result: got R=%h mode=%b, expected R=%h mode=%b",
                     R2, out_mode2, e.r, e.m);
          end
        end
      end
      if (in_valid2 && in_ready2) begin
        ap  = ref_mul(4, 3, 16'(A2), 16'(B2), mode2);
        ex  = ref_mul(4, 3, 16'(A2), 16'(B2), 1'b0);
        e.r = ap[15:0];
        e.m = mode2;
        e.e = 16'(ex - ap);
        err_sum2 += longint'(e.e);
        if (int'(e.e) > err_max2_exp) err_max2_exp = int'(e.e);
        sb2.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain1();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb1.size() != 0; i++) step();
    n_checks++;
    if (sb1.size() != 0) begin
      n_fail++;
      $display("FAIL drain1: %0d results still pending, expected 0", sb1.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || R !== 16'h0 || out_mode !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b R=%h m=%b rdy=%b, expected 0 0000 0 1",
               out_valid, R, out_mode, in_ready);
    end
    step();
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || in_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b v=%b rdy2=%b v2=%b, expected 1 0 1 0",
               in_ready, out_valid, in_ready2, out_valid2);
    end
  endtask

  task automatic test_single(input logic m, input logic [15:0] exp_r, input logic [15:0] exp_e);
    A = 8'd255; B = 8'd255; mode = m; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: got out_valid=%b after 1 cycle, expected 0", out_valid);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || R !== exp_r || out_mode !== m) begin
      n_fail++;
      $display("FAIL latency_result: got v=%b R=%h m=%b, expected 1 %h %b",
               out_valid, R, out_mode, exp_r, m);
    end
`ifdef CDM_ERR_STAT_EN
    n_checks++;
    if (err !== exp_e) begin
      n_fail++;
      $display("FAIL single_err: got %0d, expected %0d", err, exp_e);
    end
`else
    if (exp_e == 16'hFFFF) $display("note: unexpected err value");
`endif
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_tail: got out_valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  va [3] = '{8'd3, 8'h10, 8'd0};
    logic [7:0]  vb [3] = '{8'd3, 8'h10, 8'd200};
    logic [15:0] vr [3] = '{16'd5, 16'd256, 16'd0};
    out_ready = 1'b1;
    mode      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        A = va[i]; B = vb[i]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i >= 1 && i <= 3) begin
        n_checks++;
        if (out_valid !== 1'b1 || R !== vr[i-1]) begin
          n_fail++;
          $display("FAIL b2b_%0d: got v=%b R=%0d, expected 1 %0d", i - 1, out_valid, R, vr[i-1]);
        end
      end
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: got out_valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_stall();
    int          acc = 0;
    int          out_before;
    logic [31:0] first;
    first     = ref_mul(8, 8, 16'd10, 16'd20, 1'b1);
    out_ready = 1'b0;
    mode      = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      A = 8'(10 + i); B = 8'(20 + i);
      if (in_ready) acc++;
      step();
      if (i >= 1) begin
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || R !== first[15:0]) begin
          n_fail++;
          $display("FAIL stall_hold_%0d: got v=%b rdy=%b R=%h, expected 1 0 %h",
                   i, out_valid, in_ready, R, first[15:0]);
        end
      end
    end
    n_checks++;
    if (acc != 2) begin
      n_fail++;
      $display("FAIL stall_accepts: got %0d, expected 2", acc);
    end
    out_before = n_out1;
    drain1();
    n_checks++;
    if (n_out1 - out_before != 2) begin
      n_fail++;
      $display("FAIL stall_drain_count: got %0d, expected 2", n_out1 - out_before);
    end
  endtask

  task automatic test_rst_midflight();
    int out_before;
    out_ready = 1'b0;
    A = 8'hAB; B = 8'hCD; mode = 1'b1; in_valid = 1'b1;
    step();
    A = 8'h77; B = 8'h99; mode = 1'b0;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    sb1.delete();
    n_checks++;
    if (out_valid !== 1'b0 || R !== 16'h0 || out_mode !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_clear: got v=%b R=%h m=%b, expected 0 0000 0", out_valid, R, out_mode);
    end
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_ready: got in_ready=%b, expected 1", in_ready);
    end
    out_before = n_out1;
    for (int i = 0; i < 6; i++) step();
    n_checks++;
    if (n_out1 != out_before || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_ghost: got %0d outputs after reset, expected 0", n_out1 - out_before);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      A         = 8'($urandom);
      B         = 8'($urandom);
      mode      = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain1();
  endtask

  task automatic test_sweep8();
    out_ready = 1'b1;
    mode      = 1'b1;
    in_valid  = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        A = 8'(a); B = 8'(b);
        step();
      end
    end
    drain1();
  endtask

  task automatic test_sweep4();
    out_ready2 = 1'b1;
    mode2      = 1'b1;
    in_valid2  = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        A2 = 4'(a); B2 = 4'(b);
        step();
      end
    end
    in_valid2 = 1'b0;
    for (int i = 0; i < 10 && sb2.size() != 0; i++) step();
    step();
    n_checks++;
    if (sb2.size() != 0 || n_out2 != 256) begin
      n_fail++;
      $display("FAIL sweep4_count: got %0d outputs, %0d pending, expected 256 and 0",
               n_out2, sb2.size());
    end
`ifdef CDM_ERR_STAT_EN
    n_checks++;
    if (longint'(err_acc2) != err_sum2 || n_txn2 !== 32'd256 || int'(err_max2) != err_max2_exp) begin
      n_fail++;
      $display("FAIL sweep4_stats: got acc=%0d n=%0d max=%0d, expected %0d 256 %0d",
               err_acc2, n_txn2, err_max2, err_sum2, err_max2_exp);
    end
    stat_clr2 = 1'b1;
    step();
    stat_clr2 = 1'b0;
    n_checks++;
    if (err_acc2 !== 32'd0 || n_txn2 !== 32'd0 || err_max2 !== 8'd0) begin
      n_fail++;
      $display("FAIL stat_clr: got acc=%0d n=%0d max=%0d, expected 0 0 0",
               err_acc2, n_txn2, err_max2);
    end
`endif
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; mode = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; A2 = '0; B2 = '0; mode2 = 1'b0;
`ifdef CDM_ERR_STAT_EN
    stat_clr = 1'b0;
    stat_clr2 = 1'b0;
`endif
    test_reset();
    test_single(1'b1, 16'hF755, 16'd1708);
    test_single(1'b0, 16'hFE01, 16'd0);
    test_back_to_back();
    test_stall();
    test_rst_midflight();
    test_random();
    test_sweep8();
    test_sweep4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
